// File: rtl/gpr_regfile_pkg.sv
// rtl/gpr_regfile_pkg.sv - shared constants, FSM encoding and ABI indices for the GPR file
// Optional feature macro used by this slice: GPR_BYPASS_EN (same-cycle write forwarding).
package gpr_regfile_pkg;

  localparam int GPR_NUM        = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_XLEN       = 32;

  localparam int GPR_ST_WIDTH = 1;
  typedef enum logic [GPR_ST_WIDTH-1:0] {
    GPR_ST_CLEAR = 1'b0,
    GPR_ST_READY = 1'b1
  } gpr_state_e;

  localparam int GPR_ZERO = 0;
  localparam int GPR_RA   = 1;
  localparam int GPR_SP   = 2;
  localparam int GPR_A0   = 10;

endpackage

// File: rtl/gpr_regfile_read_port.sv
// rtl/gpr_regfile_read_port.sv - one combinational read port with x0/range/ready zeroing
// Macro GPR_BYPASS_EN adds forwarding of the write presented in the same cycle.
module gpr_read_port #(
  parameter int NR_REG     = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] regs_i [NR_REG],
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  ready_i,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Extra bit keeps the range compare meaningful when 2**ADDR_WIDTH == NR_REG.
  localparam logic [ADDR_WIDTH:0] NR_REG_EXT = (ADDR_WIDTH+1)'(NR_REG);

  logic in_range;
  assign in_range = ({1'b0, addr_i} < NR_REG_EXT);

`ifndef GPR_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_valid_i, wr_addr_i, wr_data_i};
`endif

  always_comb begin
    data_o = '0;
    if (ready_i && (addr_i != '0) && in_range) begin
`ifdef GPR_BYPASS_EN
      if (wr_valid_i && (wr_addr_i == addr_i)) begin
        data_o = wr_data_i;
      end else begin
        data_o = regs_i[addr_i];
      end
`else
      data_o = regs_i[addr_i];
`endif
    end
  end

endmodule

// File: rtl/gpr_regfile.sv
// rtl/gpr_regfile.sv - integer GPR file with self-clearing FSM, two source ports and a debug port
// Macro GPR_BYPASS_EN enables same-cycle forwarding on all three read ports.
module gpr_regfile
  import gpr_regfile_pkg::*;
#(
  parameter int NR_REG     = GPR_NUM,
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] srd,
  input  logic                  gpr_w_en,
  output logic                  rf_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NR_REG - 1);
  localparam logic [ADDR_WIDTH:0]   NR_REG_EXT = (ADDR_WIDTH+1)'(NR_REG);

  logic [DATA_WIDTH-1:0] regs_q [NR_REG];
  gpr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic                  clr_we;
  logic                  wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GPR_ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      GPR_ST_CLEAR: begin
        clr_we    = !rst;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = GPR_ST_READY;
        end
      end
      GPR_ST_READY: begin
        state_d = GPR_ST_READY;
      end
      default: begin
        state_d = GPR_ST_CLEAR;
      end
    endcase
  end

  // Ready drops combinationally with rst so nothing is accepted while reset is held.
  assign rf_ready = (state_q == GPR_ST_READY) && !rst;

  assign wr_valid = rf_ready && gpr_w_en && (rd_addr != '0) &&
                    ({1'b0, rd_addr} < NR_REG_EXT);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_valid) begin
      regs_q[rd_addr] <= srd;
    end
  end

  gpr_read_port #(.NR_REG(NR_REG), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_src1 (
    .regs_i(regs_q), .addr_i(rs1_addr), .ready_i(rf_ready),
    .wr_valid_i(wr_valid), .wr_addr_i(rd_addr), .wr_data_i(srd), .data_o(src1)
  );

  gpr_read_port #(.NR_REG(NR_REG), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_src2 (
    .regs_i(regs_q), .addr_i(rs2_addr), .ready_i(rf_ready),
    .wr_valid_i(wr_valid), .wr_addr_i(rd_addr), .wr_data_i(srd), .data_o(src2)
  );

  gpr_read_port #(.NR_REG(NR_REG), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_dbg (
    .regs_i(regs_q), .addr_i(dbg_addr), .ready_i(rf_ready),
    .wr_valid_i(wr_valid), .wr_addr_i(rd_addr), .wr_data_i(srd), .data_o(dbg_data)
  );

endmodule

// File: tb/tb_gpr_regfile.sv
// tb/tb_gpr_regfile.sv - directed self-checking bench for gpr_regfile
// Expectations for the same-cycle read depend on GPR_BYPASS_EN.
module tb_gpr_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [31:0] src1, src2, srd, dbg_data;
  logic        gpr_w_en;
  logic        rf_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [32];

  gpr_regfile dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .src1(src1), .src2(src2),
    .rd_addr(rd_addr), .srd(srd), .gpr_w_en(gpr_w_en),
    .rf_ready(rf_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sweep(input string tag);
    gpr_w_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("%s dbg x%0d", tag, i), dbg_data, exp_regs[i]);
    end
  endtask

  initial begin
    rst = 1'b1; gpr_w_en = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; dbg_addr = '0; srd = '0;
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;

    // Reset held for 3 cycles
    step(); step(); step();
    chk("ready in rst", 32'(rf_ready), 32'd0);
    rst = 1'b0;

    // Clear phase with a write attempt to x3 that must be dropped
    gpr_w_en = 1'b1; rd_addr = 5'd3; srd = 32'hFF; rs1_addr = 5'd3;
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("ready low clr c%0d", c), 32'(rf_ready), 32'd0);
      chk($sformatf("src1 zero clr c%0d", c), src1, 32'd0);
      step();
    end
    gpr_w_en = 1'b0;
    chk("ready after clear", 32'(rf_ready), 32'd1);
    sweep("post clear");

    // Write x5, read on both source ports next cycle
    rd_addr = 5'd5; srd = 32'hDEADBEEF; gpr_w_en = 1'b1;
    step();
    gpr_w_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    exp_regs[5] = 32'hDEADBEEF;
    chk("src1 x5", src1, 32'hDEADBEEF);
    chk("src2 x5", src2, 32'hDEADBEEF);

    // Upper boundary index
    rd_addr = 5'd31; srd = 32'h31313131; gpr_w_en = 1'b1;
    step();
    gpr_w_en = 1'b0; rs2_addr = 5'd31;
    #1;
    exp_regs[31] = 32'h31313131;
    chk("src2 x31", src2, 32'h31313131);

    // Write to x0 is discarded
    rd_addr = 5'd0; srd = 32'h12345678; gpr_w_en = 1'b1; rs1_addr = 5'd0;
    step();
    gpr_w_en = 1'b0;
    #1;
    chk("src1 x0", src1, 32'd0);
    sweep("after x0 write");

    // Same-cycle write/read of x7
    rd_addr = 5'd7; srd = 32'h11111111; gpr_w_en = 1'b1;
    step();
    rd_addr = 5'd7; srd = 32'hA5A5A5A5; gpr_w_en = 1'b1; rs1_addr = 5'd7;
    #1;
`ifdef GPR_BYPASS_EN
    chk("src1 x7 same cycle", src1, 32'hA5A5A5A5);
`else
    chk("src1 x7 same cycle", src1, 32'h11111111);
`endif
    step();
    gpr_w_en = 1'b0;
    #1;
    chk("src1 x7 next cycle", src1, 32'hA5A5A5A5);

    // Reset from READY, then a second reset pulse at clr_idx 10
    rs1_addr = 5'd5;
    rst = 1'b1;
    #1;
    chk("ready drops with rst", 32'(rf_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("src1 zero pre-pulse c%0d", c), src1, 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("ready low restart c%0d", c), 32'(rf_ready), 32'd0);
      step();
    end
    chk("ready after restart", 32'(rf_ready), 32'd1);
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    sweep("after restart");
    #1;
    chk("src1 x5 cleared", src1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
